// File: rtl/skylark_core.sv
// rtl/skylark_core.sv - three-stage (fetch / execute / writeback) RV32I core
// Branches resolve in execute with a one-cycle flush; writeback results forward straight into execute.
module skylark_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrF,
  input  logic [31:0] ReadData,
  output logic        MemWriteW,
  output logic [31:0] ALUResultW,
  output logic [31:0] WriteData,
  output logic [31:0] PCF
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] instr_e, pc_e;
  logic [31:0] regs [32];
  logic [4:0]  rd_w;
  logic        reg_write_w, load_w;
  logic [31:0] result_w;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] src_a, src_b;
  logic        reg_write_e, mem_write_e, load_e, taken;
  logic [31:0] result_e, target;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << sh;
      3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'd0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  assign result_w = load_w ? ReadData : ALUResultW;

  assign opcode = instr_e[6:0];
  assign rd     = instr_e[11:7];
  assign funct3 = instr_e[14:12];
  assign rs1    = instr_e[19:15];
  assign rs2    = instr_e[24:20];
  assign funct7 = instr_e[31:25];
  assign imm_i  = {{20{instr_e[31]}}, instr_e[31:20]};
  assign imm_s  = {{20{instr_e[31]}}, instr_e[31:25], instr_e[11:7]};
  assign imm_b  = {{19{instr_e[31]}}, instr_e[31], instr_e[7], instr_e[30:25], instr_e[11:8], 1'b0};
  assign imm_u  = {instr_e[31:12], 12'd0};
  assign imm_j  = {{11{instr_e[31]}}, instr_e[31], instr_e[19:12], instr_e[20], instr_e[30:21], 1'b0};

  // The writeback result bypasses the register file, which also covers same-cycle write/read.
  always_comb begin
    src_a = regs[rs1];
    src_b = regs[rs2];
    if (rs1 == 5'd0) src_a = 32'd0;
    else if (reg_write_w && rd_w == rs1) src_a = result_w;
    if (rs2 == 5'd0) src_b = 32'd0;
    else if (reg_write_w && rd_w == rs2) src_b = result_w;
  end

  always_comb begin
    reg_write_e = 1'b0;
    mem_write_e = 1'b0;
    load_e      = 1'b0;
    taken       = 1'b0;
    result_e    = 32'd0;
    target      = pc_e + imm_b;
    case (opcode)
      OP_LUI: begin
        reg_write_e = 1'b1;
        result_e    = imm_u;
      end
      OP_AUIPC: begin
        reg_write_e = 1'b1;
        result_e    = pc_e + imm_u;
      end
      OP_JAL: begin
        reg_write_e = 1'b1;
        result_e    = pc_e + 32'd4;
        taken       = 1'b1;
        target      = pc_e + imm_j;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        reg_write_e = 1'b1;
        result_e    = pc_e + 32'd4;
        taken       = 1'b1;
        target      = (src_a + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  taken = src_a == src_b;
          3'b001:  taken = src_a != src_b;
          3'b100:  taken = $signed(src_a) <  $signed(src_b);
          3'b101:  taken = $signed(src_a) >= $signed(src_b);
          3'b110:  taken = src_a <  src_b;
          3'b111:  taken = src_a >= src_b;
          default: taken = 1'b0;
        endcase
      end
      OP_LOAD: if (funct3 == 3'b010) begin
        reg_write_e = 1'b1;
        load_e      = 1'b1;
        result_e    = src_a + imm_i;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        mem_write_e = 1'b1;
        result_e    = src_a + imm_s;
      end
      OP_IMM: begin
        // Shift-immediates carry funct7 in the immediate; any other encoding is treated as a NOP.
        if (!((funct3 == 3'b001 && funct7 != 7'h00) ||
              (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20))) begin
          reg_write_e = 1'b1;
          result_e    = alu(funct3, funct3 == 3'b101 && funct7[5], src_a, imm_i);
        end
      end
      OP_REG: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          reg_write_e = 1'b1;
          result_e    = alu(funct3, funct7[5], src_a, src_b);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      PCF         <= 32'd0;
      instr_e     <= NOP;
      pc_e        <= 32'd0;
      MemWriteW   <= 1'b0;
      ALUResultW  <= 32'd0;
      WriteData   <= 32'd0;
      rd_w        <= 5'd0;
      reg_write_w <= 1'b0;
      load_w      <= 1'b0;
    end else begin
      PCF         <= taken ? target : PCF + 32'd4;
      instr_e     <= taken ? NOP : InstrF;
      pc_e        <= PCF;
      MemWriteW   <= mem_write_e;
      ALUResultW  <= result_e;
      WriteData   <= src_b;
      rd_w        <= rd;
      reg_write_w <= reg_write_e && rd != 5'd0;
      load_w      <= load_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (reg_write_w) begin
      regs[rd_w] <= result_w;
    end
  end

endmodule

// File: tb/tb_skylark_core.sv
// tb/tb_skylark_core.sv - directed program bench for skylark_core
// Single-instruction ALU vectors from a table, then hand-written hazard/branch/reset programs.
module tb_skylark_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] InstrF, ReadData, ALUResultW, WriteData, PCF;
  logic        MemWriteW;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  logic [31:0] pc_trace [32];
  logic [31:0] st_addr [$];
  logic [31:0] st_data [$];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, OPI = 7'b0010011,
                         LD = 7'b0000011, JALR = 7'b1100111, SYS = 7'b1110011;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [$];

  skylark_core dut (
    .clk(clk), .reset(reset), .InstrF(InstrF), .ReadData(ReadData),
    .MemWriteW(MemWriteW), .ALUResultW(ALUResultW), .WriteData(WriteData), .PCF(PCF)
  );

  always #5 clk = ~clk;

  assign InstrF   = imem[PCF[7:2]];
  assign ReadData = dmem[ALUResultW[5:2]];

  always @(posedge clk) if (MemWriteW) dmem[ALUResultW[5:2]] <= WriteData;

  always @(negedge clk) if (MemWriteW && reset) begin
    st_addr.push_back(ALUResultW);
    st_data.push_back(WriteData);
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_store(input string name, input int idx, input logic [31:0] addr, input logic [31:0] data);
    n_checks++;
    if (st_addr.size() <= idx) begin
      n_fail++;
      $display("FAIL %s: only %0d stores seen, expected store #%0d to 0x%08h", name, st_addr.size(), idx, addr);
    end else begin
      n_checks++;
      if (st_addr[idx] !== addr || st_data[idx] !== data) begin
        n_fail++;
        $display("FAIL %s: got addr 0x%08h data 0x%08h, expected addr 0x%08h data 0x%08h",
                 name, st_addr[idx], st_data[idx], addr, data);
      end
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.instr = instr; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  // Holds reset for two edges (mid-program when something was running), then runs n cycles.
  task automatic run(input int n);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("store strobe during reset", {31'd0, MemWriteW}, 32'd0);
    @(negedge clk);
    check("PCF at reset", PCF, 32'd0);
    check("MemWriteW at reset", {31'd0, MemWriteW}, 32'd0);
    check("ALUResultW at reset", ALUResultW, 32'd0);
    check("WriteData at reset", WriteData, 32'd0);
    st_addr.delete();
    st_data.delete();
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      pc_trace[k] = PCF;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] hi, hb;
    for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
    clear_imem();

    add_vec("ADD",          enc_r(7'h00, 2, 1, 3'b000, 3), 32'd5,        32'd7,        32'd12);
    add_vec("ADD wrap",     enc_r(7'h00, 2, 1, 3'b000, 3), 32'h7FFFFFFF, 32'd1,        32'h80000000);
    add_vec("SUB",          enc_r(7'h20, 2, 1, 3'b000, 3), 32'd5,        32'd7,        32'hFFFFFFFE);
    add_vec("SLL shamt5",   enc_r(7'h00, 2, 1, 3'b001, 3), 32'd1,        32'd33,       32'd2);
    add_vec("SLT signed",   enc_r(7'h00, 2, 1, 3'b010, 3), 32'hFFFFFFFF, 32'd1,        32'd1);
    add_vec("SLTU",         enc_r(7'h00, 2, 1, 3'b011, 3), 32'hFFFFFFFF, 32'd1,        32'd0);
    add_vec("XOR",          enc_r(7'h00, 2, 1, 3'b100, 3), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
    add_vec("SRL",          enc_r(7'h00, 2, 1, 3'b101, 3), 32'h80000000, 32'd4,        32'h08000000);
    add_vec("SRA",          enc_r(7'h20, 2, 1, 3'b101, 3), 32'h80000000, 32'd4,        32'hF8000000);
    add_vec("OR",           enc_r(7'h00, 2, 1, 3'b110, 3), 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF);
    add_vec("AND",          enc_r(7'h00, 2, 1, 3'b111, 3), 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00);
    add_vec("ADDI neg",     enc_i(32'hFFFFFFFF, 1, 3'b000, 3, OPI), 32'd0, 32'd0, 32'hFFFFFFFF);
    add_vec("SLTIU -1",     enc_i(32'hFFFFFFFF, 1, 3'b011, 3, OPI), 32'd5, 32'd0, 32'd1);
    add_vec("XORI -1",      enc_i(32'hFFFFFFFF, 1, 3'b100, 3, OPI), 32'h0000FFFF, 32'd0, 32'hFFFF0000);
    add_vec("SRAI 31",      enc_i(32'h41F, 1, 3'b101, 3, OPI), 32'h80000000, 32'd0, 32'hFFFFFFFF);
    add_vec("LUI",          enc_u(20'hABCDE, 3, LUI), 32'd0, 32'd0, 32'hABCDE000);
    add_vec("AUIPC",        enc_u(20'h00001, 3, AUIPC), 32'd0, 32'd0, 32'h00001010);
    add_vec("bad SLLI nop", enc_i(32'h401, 1, 3'b001, 3, OPI), 32'd1, 32'd0, 32'd0);
    add_vec("LB nop",       enc_i(32'd0, 0, 3'b000, 3, LD), 32'd0, 32'd0, 32'd0);
    add_vec("ECALL nop",    32'h00000073, 32'd0, 32'd0, 32'd0);
    add_vec("CSRRW nop",    enc_i(32'h300, 1, 3'b001, 3, SYS), 32'd9, 32'd0, 32'd0);

    for (int v = 0; v < vecs.size(); v++) begin
      clear_imem();
      hi = vecs[v].a + 32'h800;
      hb = vecs[v].b + 32'h800;
      imem[0] = enc_u(hi[31:12], 1, LUI);
      imem[1] = enc_i(vecs[v].a, 1, 3'b000, 1, OPI);
      imem[2] = enc_u(hb[31:12], 2, LUI);
      imem[3] = enc_i(vecs[v].b, 2, 3'b000, 2, OPI);
      imem[4] = vecs[v].instr;
      imem[5] = enc_s(32'd0, 3, 0);
      run(10);
      check_store(vecs[v].name, 0, 32'd0, vecs[v].exp);
    end

    // PC walk and back-to-back forwarding into a store
    clear_imem();
    imem[0] = enc_i(32'd5, 0, 3'b000, 1, OPI);
    imem[1] = enc_i(32'd7, 1, 3'b000, 2, OPI);
    imem[2] = enc_s(32'd0, 2, 0);
    run(8);
    for (int k = 0; k < 8; k++) check($sformatf("PCF step %0d", k), pc_trace[k], 32'(4 * k));
    check_store("fwd ADDI chain", 0, 32'd0, 32'd12);

    // Load-use forwarding from ReadData
    clear_imem();
    imem[0] = enc_u(20'h00001, 1, LUI);
    imem[1] = enc_i(32'h234, 1, 3'b000, 1, OPI);
    imem[2] = enc_s(32'd8, 1, 0);
    imem[3] = enc_i(32'd8, 0, 3'b010, 3, LD);
    imem[4] = enc_r(7'h00, 3, 3, 3'b000, 4);
    imem[5] = enc_s(32'd12, 4, 0);
    run(10);
    check_store("SW 0x1234", 0, 32'd8, 32'h1234);
    check_store("LW fwd ADD", 1, 32'd12, 32'h2468);

    // Taken BEQ flushes the shadow instruction
    clear_imem();
    imem[4] = enc_b(32'd8, 0, 0, 3'b000);
    imem[5] = enc_i(32'd1, 0, 3'b000, 5, OPI);
    imem[6] = enc_s(32'd0, 5, 0);
    run(10);
    check("PCF at BEQ+4", pc_trace[5], 32'h14);
    check("PCF after BEQ", pc_trace[6], 32'h18);
    check_store("BEQ shadow no write", 0, 32'd0, 32'd0);

    // JAL link value
    clear_imem();
    imem[8]  = enc_j(32'd12, 1);
    imem[9]  = enc_i(32'h77, 0, 3'b000, 1, OPI);
    imem[11] = enc_s(32'd0, 1, 0);
    run(16);
    check_store("JAL link", 0, 32'd0, 32'h24);

    // JALR clears target bit 0
    clear_imem();
    imem[0] = enc_i(32'h11, 0, 3'b000, 1, OPI);
    imem[1] = enc_i(32'd4, 1, 3'b000, 2, JALR);
    imem[2] = enc_i(32'h55, 0, 3'b000, 2, OPI);
    imem[5] = enc_s(32'd0, 2, 0);
    run(10);
    check("PCF after JALR", pc_trace[3], 32'h14);
    check_store("JALR link", 0, 32'd0, 32'd8);

    // x0 stays zero
    clear_imem();
    imem[0] = enc_i(32'd9, 0, 3'b000, 0, OPI);
    imem[1] = enc_s(32'd4, 0, 0);
    run(8);
    check_store("x0 immutable", 0, 32'd4, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
